// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, request coordinates issued
// LOOKAHEAD pixels ahead, and a tick-enabled sync/enable pipeline aligned with ColorOut.
module vga_timing_gen #(
  parameter int COLOR_W   = 16,
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int LOOKAHEAD = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] ColorIn,
  output logic [H_W-1:0]     PixelCount,
  output logic [V_W-1:0]     LineCount,
  output logic               pix_tick,
  output logic               LineStart,
  output logic               FrameStart,
  output logic               Hsync,
  output logic               Vsync,
  output logic               Active,
  output logic [COLOR_W-1:0] ColorOut
);

  // Region boundaries are formed at full integer width, then cut to counter width.
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic           HP       = 1'(H_POL);
  localparam logic           VP       = 1'(V_POL);

  logic       h_last, v_last;
  logic [2:0] dec_p0;
  logic [2:0] pre_p1;

  // Stage: clock divider producing the pixel tick
  if (CLK_DIV > 1) begin : g_div
    localparam int SUB_W = $clog2(CLK_DIV);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_DIV - 1);
    logic [SUB_W-1:0] sub;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sub <= '0;
      end else if (en) begin
        sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
      end
    end

    assign pix_tick = en & ~rst & (sub == SUB_LAST);
  end else begin : g_nodiv
    assign pix_tick = en & ~rst;
  end

  assign h_last = (PixelCount == H_LAST);
  assign v_last = (LineCount == V_LAST);

  // Stage: request position counters and wrap pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PixelCount <= '0;
      LineCount  <= '0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      LineStart  <= pix_tick & h_last;
      FrameStart <= pix_tick & h_last & v_last;
      if (pix_tick) begin
        if (h_last) begin
          PixelCount <= '0;
          LineCount  <= v_last ? '0 : LineCount + 1'b1;
        end else begin
          PixelCount <= PixelCount + 1'b1;
        end
      end
    end
  end

  // Stage p0: decode {hs, vs, de} of the current request position
  always_comb begin
    dec_p0    = 3'b000;
    dec_p0[2] = (PixelCount >= HS_BEG) && (PixelCount < HS_END);
    dec_p0[1] = (LineCount >= VS_BEG) && (LineCount < VS_END);
    dec_p0[0] = (PixelCount < H_ACT) && (LineCount < V_ACT);
  end

  // Stage p1: LOOKAHEAD-1 tick-enabled delay stages
  if (LOOKAHEAD > 1) begin : g_dly
    logic [2:0] dly_p1 [LOOKAHEAD-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LOOKAHEAD - 1; i++) dly_p1[i] <= 3'b000;
      end else if (pix_tick) begin
        dly_p1[0] <= dec_p0;
        for (int i = 1; i < LOOKAHEAD - 1; i++) dly_p1[i] <= dly_p1[i-1];
      end
    end

    assign pre_p1 = dly_p1[LOOKAHEAD-2];
  end else begin : g_nodly
    assign pre_p1 = dec_p0;
  end

  // Stage p2: output register; ColorIn is sampled on the same tick as its enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hsync    <= ~HP;
      Vsync    <= ~VP;
      Active   <= 1'b0;
      ColorOut <= '0;
    end else if (pix_tick) begin
      Hsync    <= pre_p1[2] ? HP : ~HP;
      Vsync    <= pre_p1[1] ? VP : ~VP;
      Active   <= pre_p1[0];
      ColorOut <= pre_p1[0] ? ColorIn : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations compared every cycle with an
// arithmetic raster model, plus a vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div, la, hp, vp, hw, cw;
  } cfg_t;

  cfg_t cfg_a = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 3, 0, 0, 3, 8};
  cfg_t cfg_b = '{6, 2, 3, 1, 4, 1, 2, 1, 3, 2, 1, 1, 4, 8};
  cfg_t cfg_c = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 0, 0, 10, 16};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] colour(input cfg_t c, input int h, input int v);
    longint x;
    x = (longint'(v) << c.hw) | longint'(h);
    return 32'(x & ((64'd1 << c.cw) - 1));
  endfunction

  // Colour for the position whose output tick is the next tick to come.
  function automatic logic [31:0] nextcol(input cfg_t c, input longint ecnt);
    longint t, p, n;
    int ht;
    ht = c.ha + c.hf + c.hs + c.hb;
    n  = longint'(ht) * (c.va + c.vf + c.vs + c.vb);
    t  = ecnt / c.div;
    p  = t + 1 - c.la;
    if (p < 0) p = 0;
    p = p % n;
    return colour(c, int'(p % ht), int'(p / ht));
  endfunction

  // Expected outputs after ecnt enabled clocks since reset.
  function automatic logic [63:0] model(input cfg_t c, input longint ecnt, input bit last_en,
                                        input bit en, input bit rst);
    int ht, h, v, h2, v2;
    longint n, t, p;
    bit tick, ls, fs, hs, vs, de, hsy, vsy;
    logic [31:0] col;
    ht = c.ha + c.hf + c.hs + c.hb;
    n  = longint'(ht) * (c.va + c.vf + c.vs + c.vb);
    t  = ecnt / c.div;
    h  = int'((t % n) % ht);
    v  = int'((t % n) / ht);
    tick = en && !rst && (ecnt % c.div == c.div - 1);
    ls   = last_en && ecnt > 0 && (ecnt % c.div == 0) && h == 0;
    fs   = ls && v == 0;
    hs = 0; vs = 0; de = 0; col = 0;
    if (t >= c.la) begin
      p  = (t - c.la) % n;
      h2 = int'(p % ht);
      v2 = int'(p / ht);
      hs = h2 >= c.ha + c.hf && h2 < c.ha + c.hf + c.hs;
      vs = v2 >= c.va + c.vf && v2 < c.va + c.vf + c.vs;
      de = h2 < c.ha && v2 < c.va;
      if (de) col = colour(c, h2, v2);
    end
    hsy = hs ? (c.hp != 0) : (c.hp == 0);
    vsy = vs ? (c.vp != 0) : (c.vp == 0);
    return {16'(h), 16'(v), tick, ls, fs, hsy, vsy, de, 10'd0, col[15:0]};
  endfunction

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic meas = 1'b0;

  logic [7:0]  cin_a, col_a, cin_b, col_b;
  logic [15:0] cin_c, col_c;
  logic [2:0]  pc_a, lc_a, lc_b;
  logic [3:0]  pc_b;
  logic [9:0]  pc_c, lc_c;
  logic tick_a, ls_a, fs_a, hs_a, vs_a, de_a;
  logic tick_b, ls_b, fs_b, hs_b, vs_b, de_b;
  logic tick_c, ls_c, fs_c, hs_c, vs_c, de_c;

  longint ecnt_a = 0, ecnt_b = 0, ecnt_c = 0;
  bit     le_a = 0, le_b = 0, le_c = 0;

  always @(posedge clk or posedge rst_a)
    if (rst_a) begin ecnt_a <= 0; le_a <= 0; end
    else begin le_a <= en_a; if (en_a) ecnt_a <= ecnt_a + 1; end
  always @(posedge clk or posedge rst_b)
    if (rst_b) begin ecnt_b <= 0; le_b <= 0; end
    else begin le_b <= en_b; if (en_b) ecnt_b <= ecnt_b + 1; end
  always @(posedge clk or posedge rst_c)
    if (rst_c) begin ecnt_c <= 0; le_c <= 0; end
    else begin le_c <= en_c; if (en_c) ecnt_c <= ecnt_c + 1; end

  assign cin_a = 8'(nextcol(cfg_a, ecnt_a));
  assign cin_b = 8'(nextcol(cfg_b, ecnt_b));
  assign cin_c = 16'(nextcol(cfg_c, ecnt_c));

  vga_timing_gen #(.COLOR_W(8), .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(0), .V_POL(0),
                   .LOOKAHEAD(3)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .ColorIn(cin_a), .PixelCount(pc_a), .LineCount(lc_a),
    .pix_tick(tick_a), .LineStart(ls_a), .FrameStart(fs_a), .Hsync(hs_a), .Vsync(vs_a),
    .Active(de_a), .ColorOut(col_a));

  vga_timing_gen #(.COLOR_W(8), .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1),
                   .LOOKAHEAD(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .ColorIn(cin_b), .PixelCount(pc_b), .LineCount(lc_b),
    .pix_tick(tick_b), .LineStart(ls_b), .FrameStart(fs_b), .Hsync(hs_b), .Vsync(vs_b),
    .Active(de_b), .ColorOut(col_b));

  vga_timing_gen #(.COLOR_W(16)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .ColorIn(cin_c), .PixelCount(pc_c), .LineCount(lc_c),
    .pix_tick(tick_c), .LineStart(ls_c), .FrameStart(fs_c), .Hsync(hs_c), .Vsync(vs_c),
    .Active(de_c), .ColorOut(col_c));

  logic [63:0] va, vb, vc;
  assign va = {16'(pc_a), 16'(lc_a), tick_a, ls_a, fs_a, hs_a, vs_a, de_a, 10'd0, 16'(col_a)};
  assign vb = {16'(pc_b), 16'(lc_b), tick_b, ls_b, fs_b, hs_b, vs_b, de_b, 10'd0, 16'(col_b)};
  assign vc = {16'(pc_c), 16'(lc_c), tick_c, ls_c, fs_c, hs_c, vs_c, de_c, 10'd0, col_c};

  always @(negedge clk) begin
    check("A_model", va, model(cfg_a, ecnt_a, le_a, en_a, rst_a));
    check("B_model", vb, model(cfg_b, ecnt_b, le_b, en_b, rst_b));
    check("C_model", vc, model(cfg_c, ecnt_c, le_c, en_c, rst_c));
  end

  // Edge-timing measurements in clk cycles while B and C run continuously.
  logic   hs_c_q = 1'b1, de_c_q = 1'b0, vs_b_q = 1'b0;
  longint t_arise = -1, t_hfall = -1, t_vrise = -1, t_fs = -1;
  int     n_hfall = 0, n_vrise = 0, n_fs = 0;

  always @(negedge clk) begin
    if (meas) begin
      if (de_c && !de_c_q) t_arise = cyc;
      if (!hs_c && hs_c_q) begin
        if (t_arise >= 0) check("C_active_to_hfall", 64'(cyc - t_arise), 64'd2624);
        if (t_hfall >= 0) check("C_hsync_period", 64'(cyc - t_hfall), 64'd3200);
        t_hfall = cyc;
        n_hfall++;
      end
      if (hs_c && !hs_c_q && t_hfall >= 0) check("C_hsync_low", 64'(cyc - t_hfall), 64'd384);
      if (vs_b && !vs_b_q) begin
        if (t_vrise >= 0) check("B_vsync_period", 64'(cyc - t_vrise), 64'd288);
        t_vrise = cyc;
        n_vrise++;
      end
      if (!vs_b && vs_b_q && t_vrise >= 0) check("B_vsync_high", 64'(cyc - t_vrise), 64'd72);
      if (fs_b) begin
        if (t_fs >= 0) check("B_frame_period", 64'(cyc - t_fs), 64'd288);
        t_fs = cyc;
        n_fs++;
      end
    end
    hs_c_q = hs_c;
    de_c_q = de_c;
    vs_b_q = vs_b;
  end

  typedef struct {
    bit en;
    int n;
    int pc, lc;
    bit hsync, vsync, act;
    int col;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int k;
    tbl[0] = '{1, 0,  0, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 3,  3, 0, 1, 1, 1, 0};
    tbl[2] = '{1, 5,  0, 1, 0, 1, 0, 0};
    tbl[3] = '{1, 3,  3, 1, 1, 1, 1, 8};
    tbl[4] = '{0, 17, 3, 1, 1, 1, 1, 8};
    tbl[5] = '{1, 26, 5, 4, 1, 0, 0, 0};
    tbl[6] = '{1, 10, 7, 5, 1, 1, 0, 0};
    tbl[7] = '{1, 5,  4, 0, 1, 1, 1, 1};

    @(posedge clk);
    #2;
    check("B_reset_hsync", 64'(hs_b), 64'd0);
    check("B_reset_vsync", 64'(vs_b), 64'd0);
    check("C_reset_hsync", 64'(hs_c), 64'd1);
    check("C_reset_color", 64'(col_c), 64'd0);
    clk_n(2);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_b = 1'b1; en_c = 1'b1; meas = 1'b1;

    for (int i = 0; i < 8; i++) begin
      en_a = tbl[i].en;
      if (tbl[i].n > 0) clk_n(tbl[i].n);
      check($sformatf("A_vec%0d_pc", i), 64'(pc_a), 64'(tbl[i].pc));
      check($sformatf("A_vec%0d_lc", i), 64'(lc_a), 64'(tbl[i].lc));
      check($sformatf("A_vec%0d_hsync", i), 64'(hs_a), 64'(tbl[i].hsync));
      check($sformatf("A_vec%0d_vsync", i), 64'(vs_a), 64'(tbl[i].vsync));
      check($sformatf("A_vec%0d_active", i), 64'(de_a), 64'(tbl[i].act));
      check($sformatf("A_vec%0d_color", i), 64'(col_a), 64'(tbl[i].col));
    end

    // Frame wrap from the last position back to (0,0)
    en_a = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (pc_a == 3'd7 && lc_a == 3'd5) break;
      clk_n(1);
    end
    check("A_reach_last_pos", 64'(k < 200), 64'd1);
    clk_n(1);
    check("A_wrap_pc", 64'(pc_a), 64'd0);
    check("A_wrap_lc", 64'(lc_a), 64'd0);
    check("A_wrap_linestart", 64'(ls_a), 64'd1);
    check("A_wrap_framestart", 64'(fs_a), 64'd1);
    clk_n(1);
    check("A_after_wrap_linestart", 64'(ls_a), 64'd0);
    check("A_after_wrap_framestart", 64'(fs_a), 64'd0);
    check("A_after_wrap_pc", 64'(pc_a), 64'd1);

    while (cyc < 13300) begin
      en_a = ($urandom_range(0, 3) != 0);
      clk_n(1);
    end
    meas = 1'b0;
    check("C_hsync_falls_seen", 64'(n_hfall >= 3), 64'd1);
    check("B_vsync_pulses_seen", 64'(n_vrise >= 10), 64'd1);
    check("B_frames_seen", 64'(n_fs >= 10), 64'd1);

    // Freeze C for 17 clk in the middle of an active line
    for (k = 0; k < 4000; k++) begin
      if (pc_c == 10'd300) break;
      clk_n(1);
    end
    check("C_reach_pixel_300", 64'(k < 4000), 64'd1);
    en_c = 1'b0;
    clk_n(17);
    check("C_hold_pc", 64'(pc_c), 64'd300);
    check("C_hold_tick", 64'(tick_c), 64'd0);
    check("C_hold_active", 64'(de_c), 64'd1);
    en_c = 1'b1;

    // Asynchronous reset of B between clock edges, mid-frame
    for (k = 0; k < 400; k++) begin
      if (lc_b == 3'd2 && pc_b == 4'd3) break;
      clk_n(1);
    end
    check("B_reach_mid_frame", 64'(k < 400), 64'd1);
    #1 rst_b = 1'b1;
    #1;
    check("B_arst_pc", 64'(pc_b), 64'd0);
    check("B_arst_lc", 64'(lc_b), 64'd0);
    check("B_arst_hsync", 64'(hs_b), 64'd0);
    check("B_arst_vsync", 64'(vs_b), 64'd0);
    check("B_arst_active", 64'(de_b), 64'd0);
    check("B_arst_color", 64'(col_b), 64'd0);
    check("B_arst_tick", 64'(tick_b), 64'd0);
    check("B_arst_pulses", 64'({ls_b, fs_b}), 64'd0);
    clk_n(1);
    rst_b = 1'b0;
    clk_n(2);
    check("B_rel_pc_before_tick", 64'(pc_b), 64'd0);
    check("B_rel_tick_third_edge", 64'(tick_b), 64'd1);
    clk_n(1);
    check("B_rel_first_tick_pc", 64'(pc_b), 64'd1);

    repeat (4000) begin
      en_a = ($urandom_range(0, 3) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      en_c = ($urandom_range(0, 7) != 0);
      clk_n(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
